// File: rtl/pathfinding_queue_ctrl.sv
// Unsorted min-priority queue controller over three parallel vertex-queue memories.
// Push appends at index count; pop scans for the smallest distance and fills the hole with the last entry.
module pathfinding_queue_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [15:0]       push_vertex,
  input  logic [15:0]       push_prev,
  input  logic [15:0]       push_dist,
  input  logic              pop_req,
  output logic              pop_done,
  output logic              pop_empty,
  output logic [15:0]       pop_vertex,
  output logic [15:0]       pop_prev,
  output logic [15:0]       pop_dist,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [15:0]       mem_addr,
  output logic              mem_wren,
  output logic [15:0]       mem_vertex_d,
  output logic [15:0]       mem_prev_d,
  output logic [15:0]       mem_dist_d,
  input  logic [15:0]       mem_vertex_q,
  input  logic [15:0]       mem_prev_q,
  input  logic [15:0]       mem_dist_q
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    SCAN,
    FINISH,
    WRITE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   scan_idx_q, scan_idx_d;
  logic [ADDR_W:0]   best_idx_q, best_idx_d;
  logic [15:0]       best_vertex_q, best_vertex_d;
  logic [15:0]       best_prev_q, best_prev_d;
  logic [15:0]       best_dist_q, best_dist_d;
  logic [15:0]       wr_vertex_q, wr_vertex_d;
  logic [15:0]       wr_prev_q, wr_prev_d;
  logic [15:0]       wr_dist_q, wr_dist_d;
  logic [15:0]       pop_vertex_q, pop_vertex_d;
  logic [15:0]       pop_prev_q, pop_prev_d;
  logic [15:0]       pop_dist_q, pop_dist_d;
  logic              pop_empty_q, pop_empty_d;

  logic [ADDR_W:0]   last_idx;
  logic [ADDR_W:0]   addr_w;
  logic              cmp_en;
  logic [ADDR_W:0]   cmp_idx;

  assign last_idx = count_q - ONE_C;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;

  assign push_ready = rst_n && (state_q == IDLE) && !full && !clear;
  assign pop_done   = (state_q == DONE);
  assign pop_empty  = (state_q == DONE) && pop_empty_q;
  assign pop_vertex = pop_vertex_q;
  assign pop_prev   = pop_prev_q;
  assign pop_dist   = pop_dist_q;
  assign mem_addr   = 16'(addr_w);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    scan_idx_d    = scan_idx_q;
    best_idx_d    = best_idx_q;
    best_vertex_d = best_vertex_q;
    best_prev_d   = best_prev_q;
    best_dist_d   = best_dist_q;
    wr_vertex_d   = wr_vertex_q;
    wr_prev_d     = wr_prev_q;
    wr_dist_d     = wr_dist_q;
    pop_vertex_d  = pop_vertex_q;
    pop_prev_d    = pop_prev_q;
    pop_dist_d    = pop_dist_q;
    pop_empty_d   = pop_empty_q;
    addr_w        = '0;
    mem_wren      = 1'b0;
    mem_vertex_d  = '0;
    mem_prev_d    = '0;
    mem_dist_d    = '0;
    cmp_en        = 1'b0;
    cmp_idx       = '0;

    case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (push_valid && !full) begin
          wr_vertex_d = push_vertex;
          wr_prev_d   = push_prev;
          wr_dist_d   = push_dist;
          state_d     = PUSH;
        end else if (pop_req) begin
          if (empty) begin
            pop_empty_d = 1'b1;
            state_d     = DONE;
          end else begin
            pop_empty_d = 1'b0;
            scan_idx_d  = '0;
            state_d     = SCAN;
          end
        end
      end
      PUSH: begin
        addr_w       = count_q;
        mem_wren     = 1'b1;
        mem_vertex_d = wr_vertex_q;
        mem_prev_d   = wr_prev_q;
        mem_dist_d   = wr_dist_q;
        count_d      = count_q + ONE_C;
        state_d      = IDLE;
      end
      SCAN: begin
        // Read data lags the address by one cycle, so this cycle sees index scan_idx-1.
        addr_w     = scan_idx_q;
        cmp_en     = (scan_idx_q != '0);
        cmp_idx    = scan_idx_q - ONE_C;
        scan_idx_d = scan_idx_q + ONE_C;
        if (scan_idx_q == last_idx) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        cmp_en      = 1'b1;
        cmp_idx     = last_idx;
        wr_vertex_d = mem_vertex_q;
        wr_prev_d   = mem_prev_q;
        wr_dist_d   = mem_dist_q;
        state_d     = WRITE;
      end
      WRITE: begin
        if (best_idx_q != last_idx) begin
          addr_w       = best_idx_q;
          mem_wren     = 1'b1;
          mem_vertex_d = wr_vertex_q;
          mem_prev_d   = wr_prev_q;
          mem_dist_d   = wr_dist_q;
        end
        pop_vertex_d = best_vertex_q;
        pop_prev_d   = best_prev_q;
        pop_dist_d   = best_dist_q;
        count_d      = last_idx;
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strict less-than keeps the lowest index on ties; index 0 always seeds the best.
    if (cmp_en && ((cmp_idx == '0) || (mem_dist_q < best_dist_q))) begin
      best_idx_d    = cmp_idx;
      best_vertex_d = mem_vertex_q;
      best_prev_d   = mem_prev_q;
      best_dist_d   = mem_dist_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      scan_idx_q    <= '0;
      best_idx_q    <= '0;
      best_vertex_q <= '0;
      best_prev_q   <= '0;
      best_dist_q   <= '0;
      wr_vertex_q   <= '0;
      wr_prev_q     <= '0;
      wr_dist_q     <= '0;
      pop_vertex_q  <= '0;
      pop_prev_q    <= '0;
      pop_dist_q    <= '0;
      pop_empty_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      scan_idx_q    <= scan_idx_d;
      best_idx_q    <= best_idx_d;
      best_vertex_q <= best_vertex_d;
      best_prev_q   <= best_prev_d;
      best_dist_q   <= best_dist_d;
      wr_vertex_q   <= wr_vertex_d;
      wr_prev_q     <= wr_prev_d;
      wr_dist_q     <= wr_dist_d;
      pop_vertex_q  <= pop_vertex_d;
      pop_prev_q    <= pop_prev_d;
      pop_dist_q    <= pop_dist_d;
      pop_empty_q   <= pop_empty_d;
    end
  end

endmodule

// File: tb/tb_pathfinding_queue_ctrl.sv
// Self-checking bench for pathfinding_queue_ctrl: memory model, array-based priority-queue
// reference, directed scenarios followed by randomized push/pop/clear traffic.
module tb_pathfinding_queue_ctrl;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef struct packed {
    logic [15:0] v;
    logic [15:0] p;
    logic [15:0] d;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [15:0]       push_vertex = '0;
  logic [15:0]       push_prev = '0;
  logic [15:0]       push_dist = '0;
  logic              pop_req = 1'b0;
  logic              pop_done;
  logic              pop_empty;
  logic [15:0]       pop_vertex;
  logic [15:0]       pop_prev;
  logic [15:0]       pop_dist;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic [15:0]       mem_addr;
  logic              mem_wren;
  logic [15:0]       mem_vertex_d;
  logic [15:0]       mem_prev_d;
  logic [15:0]       mem_dist_d;
  logic [15:0]       mem_vertex_q = '0;
  logic [15:0]       mem_prev_q = '0;
  logic [15:0]       mem_dist_q = '0;

  logic [15:0] mv [DEPTH];
  logic [15:0] mp [DEPTH];
  logic [15:0] md [DEPTH];

  entry_t ref_q[$];
  entry_t last_pop;
  int     checks = 0;
  int     failures = 0;

  pathfinding_queue_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_vertex  (push_vertex),
    .push_prev    (push_prev),
    .push_dist    (push_dist),
    .pop_req      (pop_req),
    .pop_done     (pop_done),
    .pop_empty    (pop_empty),
    .pop_vertex   (pop_vertex),
    .pop_prev     (pop_prev),
    .pop_dist     (pop_dist),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .mem_addr     (mem_addr),
    .mem_wren     (mem_wren),
    .mem_vertex_d (mem_vertex_d),
    .mem_prev_d   (mem_prev_d),
    .mem_dist_d   (mem_dist_d),
    .mem_vertex_q (mem_vertex_q),
    .mem_prev_q   (mem_prev_q),
    .mem_dist_q   (mem_dist_q)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_wren) begin
      mv[mem_addr[ADDR_W-1:0]] <= mem_vertex_d;
      mp[mem_addr[ADDR_W-1:0]] <= mem_prev_d;
      md[mem_addr[ADDR_W-1:0]] <= mem_dist_d;
    end
    mem_vertex_q <= mv[mem_addr[ADDR_W-1:0]];
    mem_prev_q   <= mp[mem_addr[ADDR_W-1:0]];
    mem_dist_q   <= md[mem_addr[ADDR_W-1:0]];
  end

  task automatic checkOutput(input string tag, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [47:0] statusOf(input int n);
    return 48'({3'(n), (n == DEPTH), (n == 0)});
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    clear = 1'b0;
    push_valid = 1'b0;
    pop_req = 1'b0;
    #1;
    checkOutput("reset_status", 48'({count, full, empty, push_ready}), 48'({3'd0, 1'b0, 1'b1, 1'b0}));
    checkOutput("reset_ctrl", 48'({pop_done, pop_empty, mem_wren, mem_addr}), 48'd0);
    checkOutput("reset_data", {pop_vertex, pop_prev, pop_dist}, 48'd0);
    checkOutput("reset_wdata", {mem_vertex_d, mem_prev_d, mem_dist_d}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_q.delete();
    last_pop = '0;
  endtask

  task automatic pushEntry(input logic [15:0] v, input logic [15:0] p, input logic [15:0] d);
    @(negedge clk);
    push_valid = 1'b1;
    push_vertex = v;
    push_prev = p;
    push_dist = d;
    #1;
    if (ref_q.size() == DEPTH) begin
      checkOutput("push_ready_full", 48'(push_ready), 48'd0);
      @(negedge clk);
      checkOutput("push_blocked_wren", 48'(mem_wren), 48'd0);
      checkOutput("push_blocked_count", 48'({count, full, empty}), statusOf(DEPTH));
      push_valid = 1'b0;
      return;
    end
    checkOutput("push_ready", 48'(push_ready), 48'd1);
    @(negedge clk);
    push_valid = 1'b0;
    checkOutput("push_write", 48'({mem_wren, mem_addr}), 48'({1'b1, 16'(ref_q.size())}));
    checkOutput("push_data", {mem_vertex_d, mem_prev_d, mem_dist_d}, {v, p, d});
    ref_q.push_back('{v, p, d});
    @(negedge clk);
    checkOutput("push_count", 48'({count, full, empty}), statusOf(ref_q.size()));
    checkOutput("push_ready_again", 48'(push_ready), 48'(ref_q.size() != DEPTH));
  endtask

  // Reference pop: smallest dist, lowest index on ties, last entry fills the hole.
  task automatic checkPopResult(input int cycles, input int exp_cycles);
    int     n;
    int     best;
    entry_t exp_e;
    n = ref_q.size();
    checkOutput("pop_latency", 48'(cycles), 48'(exp_cycles));
    checkOutput("pop_empty", 48'(pop_empty), 48'(n == 0));
    if (n == 0) begin
      exp_e = last_pop;
    end else begin
      best = 0;
      for (int i = 1; i < n; i++) begin
        if (ref_q[i].d < ref_q[best].d) best = i;
      end
      exp_e = ref_q[best];
      ref_q[best] = ref_q[n-1];
      void'(ref_q.pop_back());
      last_pop = exp_e;
    end
    checkOutput("pop_data", {pop_vertex, pop_prev, pop_dist}, exp_e);
    checkOutput("pop_count", 48'({count, full, empty}), statusOf(ref_q.size()));
    @(negedge clk);
    checkOutput("pop_done_pulse", 48'(pop_done), 48'd0);
    for (int i = 0; i < ref_q.size(); i++) begin
      checkOutput("mem_contents", {mv[i], mp[i], md[i]}, ref_q[i]);
    end
  endtask

  task automatic popEntry();
    int cycles;
    int n;
    n = ref_q.size();
    @(negedge clk);
    pop_req = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!pop_done && cycles < 100);
    pop_req = 1'b0;
    if (!pop_done) begin
      checkOutput("pop_timeout", 48'd0, 48'd1);
      return;
    end
    checkPopResult(cycles, (n == 0) ? 1 : n + 3);
  endtask

  task automatic pushAndPop(input logic [15:0] v, input logic [15:0] p, input logic [15:0] d);
    int cycles;
    @(negedge clk);
    push_valid = 1'b1;
    pop_req = 1'b1;
    push_vertex = v;
    push_prev = p;
    push_dist = d;
    #1;
    checkOutput("both_push_ready", 48'(push_ready), 48'd1);
    @(negedge clk);
    push_valid = 1'b0;
    checkOutput("both_push_first", 48'({mem_wren, mem_addr}), 48'({1'b1, 16'(ref_q.size())}));
    ref_q.push_back('{v, p, d});
    cycles = 1;
    do begin
      @(negedge clk);
      cycles++;
    end while (!pop_done && cycles < 100);
    pop_req = 1'b0;
    if (!pop_done) begin
      checkOutput("both_pop_timeout", 48'd0, 48'd1);
      return;
    end
    checkPopResult(cycles, 2 + ref_q.size() + 3);
  endtask

  task automatic applyClear(input logic with_push);
    @(negedge clk);
    clear = 1'b1;
    push_valid = with_push;
    push_vertex = 16'hBEEF;
    #1;
    checkOutput("clear_push_ready", 48'(push_ready), 48'd0);
    @(negedge clk);
    clear = 1'b0;
    push_valid = 1'b0;
    checkOutput("clear_no_wren", 48'(mem_wren), 48'd0);
    ref_q.delete();
    checkOutput("clear_count", 48'({count, full, empty}), statusOf(0));
  endtask

  task automatic resetDuringScan();
    int activity;
    @(negedge clk);
    pop_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_status", 48'({count, full, empty, push_ready}), 48'({3'd0, 1'b0, 1'b1, 1'b0}));
    checkOutput("abort_ctrl", 48'({pop_done, mem_wren, mem_addr}), 48'd0);
    pop_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_q.delete();
    last_pop = '0;
    activity = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pop_done || mem_wren) activity++;
    end
    checkOutput("abort_quiet", 48'(activity), 48'd0);
    checkOutput("abort_pop_data", {pop_vertex, pop_prev, pop_dist}, 48'd0);
  endtask

  task automatic applyStimulus(input int op);
    logic [15:0] d;
    if (op < 5) begin
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      pushEntry(16'($urandom), 16'($urandom), d);
    end else if (op < 9) begin
      popEntry();
    end else begin
      applyClear(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    last_pop = '0;
    applyReset();

    popEntry();

    pushEntry(16'd5, 16'd1, 16'd30);
    pushEntry(16'd6, 16'd1, 16'd10);
    pushEntry(16'd7, 16'd2, 16'd20);
    popEntry();
    checkOutput("min_vertex", 48'(pop_vertex), 48'd6);
    checkOutput("hole_fill", {mv[1], mp[1], md[1]}, {16'd7, 16'd2, 16'd20});
    popEntry();
    popEntry();

    pushEntry(16'd3, 16'd1, 16'd10);
    pushEntry(16'd4, 16'd1, 16'd10);
    popEntry();
    checkOutput("tie_first", 48'(pop_vertex), 48'd3);
    popEntry();
    checkOutput("tie_second", 48'({pop_vertex, empty}), 48'({16'd4, 1'b1}));

    for (int i = 0; i < DEPTH; i++) pushEntry(16'(20 + i), 16'd9, 16'(40 - i));
    checkOutput("full_flag", 48'({full, push_ready}), 48'({1'b1, 1'b0}));
    pushEntry(16'd99, 16'd9, 16'd1);
    popEntry();
    pushEntry(16'd99, 16'd9, 16'd1);
    checkOutput("refill_count", 48'(count), 48'(DEPTH));

    applyClear(1'b1);
    pushEntry(16'd11, 16'd0, 16'd50);
    pushAndPop(16'd12, 16'd0, 16'd45);
    checkOutput("both_min", 48'(pop_vertex), 48'd12);

    pushEntry(16'd1, 16'd1, 16'd5);
    pushEntry(16'd2, 16'd1, 16'd4);
    resetDuringScan();

    for (int i = 0; i < 300; i++) applyStimulus(int'($urandom_range(0, 9)));
    while (ref_q.size() != 0) popEntry();
    popEntry();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pathfinding_queue_ctrl.md
# pathfinding_queue_ctrl

Controller that sequences the three parallel vertex-queue memories (vertex, previous vertex, distance) of the Pathfinding datapath as an unsorted min-priority queue. Requesters push (vertex, prev, dist) entries and pop the entry with the smallest distance. Pop uses a linear scan followed by hole-filling with the last entry. Sits between the search FSM and the `pathfinding_mem` instances `vertex_queue_mem`, `vertex_prev_queue_mem` and `prev_vertex_dist_queue_mem`, and owns their address, data and write-enable.

## Interface
- ADDR_W, 8, queue index width; DEPTH = 2**ADDR_W entries
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  one-cycle synchronous queue flush; honoured only in IDLE
- push_valid  in  1  push request
- push_ready  out  1  high when a push is accepted this cycle
- push_vertex / push_prev / push_dist  in  16 each  entry to insert
- pop_req  in  1  level request; hold until pop_done
- pop_done  out  1  one-cycle pulse; pop result valid
- pop_empty  out  1  valid with pop_done; queue was empty
- pop_vertex / pop_prev / pop_dist  out  16 each  popped entry; held until next pop_done
- count  out  ADDR_W+1  current number of entries
- full / empty  out  1  count==DEPTH / count==0
- mem_addr  out  16  shared address to all three memories; upper bits 0
- mem_wren  out  1  shared write enable
- mem_vertex_d / mem_prev_d / mem_dist_d  out  16 each  write data
- mem_vertex_q / mem_prev_q / mem_dist_q  in  16 each  read data; valid one cycle after address

## Operation
- FSM states:
  - IDLE
  - PUSH: write one entry
  - SCAN: issue addresses 0..count-1
  - FINISH: compare the last returned word
  - WRITE: fill the hole and decrement
  - DONE: emit the result
- IDLE priority: clear, then push, then pop.
  - push_ready = (state==IDLE) && !full && !clear.
- Push: on acceptance, register the entry and go to PUSH.
  - PUSH drives mem_addr=count, mem_wren=1 and the registered data.
  - count increments at the end of PUSH.
  - Return to IDLE.
- Pop with count==0: go to DONE. pop_done=1 and pop_empty=1; the pop data outputs keep their previous values.
- Pop with count=N≥1 enters SCAN:
  - Issue address i, for i=0..N-1, one per cycle.
  - Each cycle, compare the returned dist (address i-1) against best_dist, unsigned 16-bit.
  - Replace best only on strict less-than, so ties keep the lowest index. Index 0 always initialises best.
- FINISH: compare the final word (index N-1) and also capture it as last_entry.
- WRITE:
  - If best_idx != N-1, drive mem_addr=best_idx, mem_wren=1 and last_entry data.
  - Otherwise no write.
  - Register best into the pop_* outputs.
  - count decrements at the end of WRITE.
- DONE: pop_done=1 for one cycle, then go to IDLE. pop_req is ignored in DONE.
- mem_wren=0 in every state except active PUSH/WRITE writes. mem_addr=0 in IDLE.
- clear sets count=0 and does not touch the memories.

## Timing
- Reset (async, rst_n=0): state=IDLE, count=0, empty=1, full=0, push_ready=0 during reset.
  - pop_done, pop_empty and mem_wren are 0. mem_addr, mem_*_d and pop_* are 0.
- Reset mid-operation aborts immediately.
  - Memory contents are undefined to the controller but unused, since count=0.
- Push: accepted in cycle 0, memory write in cycle 1, count updated in cycle 2; push_ready high again in cycle 2.
- Pop, N≥1: pop_req sampled in IDLE in cycle 0.
  - SCAN occupies cycles 1..N, FINISH cycle N+1, WRITE cycle N+2.
  - pop_done in cycle N+3, count updated by cycle N+3.
- Empty pop: pop_done in cycle 1.
- After DONE, pop_req still high starts a new pop in the next IDLE cycle. The requester deasserts pop_req in the pop_done cycle for a single pop.
- A push_valid asserted during a pop waits (push_ready=0) until IDLE.
- Full: push_ready stays 0; pop is still allowed. count never exceeds DEPTH and never underflows.

## Test plan
- Reset → all outputs 0, empty=1; pop_req on empty → pop_done in cycle 1 with pop_empty=1 and count=0.
- Push (5,1,30),(6,1,10),(7,2,20) then pop → pop_done in cycle 6 with (6,1,10), count=2; memory index 1 now holds (7,2,20).
- Push dists 10,10 (vertices 3,4) then pop → vertex 3 (tie keeps lowest index); pop again → vertex 4, empty=1.
- With ADDR_W=2, push 4 entries → full=1 and push_ready=0 with push_valid held; pop min → push_ready returns, fifth push is accepted, count=4.
- push_valid and pop_req together in IDLE with count=1 → push served first (count=2), then pop returns the min of both entries.
- Assert rst_n=0 during SCAN → immediate IDLE, count=0, no pop_done, and no mem_wren after release.
